// File: rtl/mips_extend_unit.sv
// Buffered MIPS operand-extension stage: imm SEXT/ZEXT/LUI, load lane extract, result FIFO.
// Optional MIPS_EXT_BYPASS_EN: zero-latency pass-through when the FIFO is empty.
module mips_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    localparam int BW   = $clog2(OUT_W / 8),
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [BW-1:0]    byte_off,
    input  logic [OUT_W-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             misalign,
    output logic [CW-1:0]    count
);

    logic [OUT_W:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [IN_W-1:0]  imm;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [OUT_W-1:0] res;
    logic             res_mis;
    logic             empty, full, push, pop;

    always_comb begin
        imm     = data_in[IN_W-1:0];
        byte_v  = data_in[{byte_off, 3'b000} +: 8];
        half_v  = data_in[{byte_off[BW-1:1], 4'b0000} +: 16];
        res     = '0;
        res_mis = 1'b0;
        unique case (mode)
            3'd0: res = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            3'd1: res = {{(OUT_W-IN_W){1'b0}}, imm};
            3'd2: res = {imm, {(OUT_W-IN_W){1'b0}}};
            3'd3: res = {{(OUT_W-8){byte_v[7]}}, byte_v};
            3'd4: res = {{(OUT_W-8){1'b0}}, byte_v};
            3'd5: begin
                if (byte_off[0]) res_mis = 1'b1;
                else res = {{(OUT_W-16){half_v[15]}}, half_v};
            end
            3'd6: begin
                if (byte_off[0]) res_mis = 1'b1;
                else res = {{(OUT_W-16){1'b0}}, half_v};
            end
            3'd7: res = data_in;
        endcase
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

`ifdef MIPS_EXT_BYPASS_EN
    // Empty FIFO: the live request is presented directly and skips storage if taken.
    logic byp;
    assign byp       = empty && in_valid;
    assign out_valid = !empty || byp;
    assign push      = in_valid && in_ready && !(byp && out_ready);
    assign data_out  = !empty ? mem_q[rd_ptr_q][OUT_W-1:0] : (byp ? res : '0);
    assign misalign  = !empty ? mem_q[rd_ptr_q][OUT_W] : (byp && res_mis);
`else
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign data_out  = !empty ? mem_q[rd_ptr_q][OUT_W-1:0] : '0;
    assign misalign  = !empty && mem_q[rd_ptr_q][OUT_W];
`endif

    assign pop = !empty && out_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= {res_mis, res};
        end
    end

endmodule

// File: tb/tb_mips_extend_unit.sv
// Bench for mips_extend_unit: directed spec vectors, FIFO/reset cases, random traffic
// checked against a queue-based arithmetic model.
module tb_mips_extend_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [1:0]  byte_off = 2'd0;
    logic [31:0] data_in = 32'd0;
    logic        in_ready, out_valid, misalign;
    logic [31:0] data_out;
    logic [1:0]  count;

    int tests = 0;
    int fails = 0;
    logic [32:0] mq[$];

    mips_extend_unit #(.IN_W(16), .OUT_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .byte_off(byte_off), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .misalign(misalign), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {misalign, value}, derived with plain arithmetic.
    function automatic logic [32:0] ref_ext(input logic [2:0] m,
                                            input logic [1:0] off,
                                            input logic [31:0] d);
        logic [31:0] v;
        logic [31:0] b;
        logic        mis;
        mis = 1'b0;
        v   = 32'd0;
        case (m)
            3'd0: begin
                v = d % 65536;
                if (v >= 32768) v = v + 32'hFFFF_0000;
            end
            3'd1: v = d % 65536;
            3'd2: v = (d % 65536) * 65536;
            3'd3, 3'd4: begin
                b = (d >> (8 * off)) % 256;
                v = (m == 3'd3 && b >= 128) ? b - 256 : b;
            end
            3'd5, 3'd6: begin
                if (off % 2 == 1) mis = 1'b1;
                else begin
                    b = (d >> (16 * (off / 2))) % 65536;
                    v = (m == 3'd5 && b >= 32768) ? b - 65536 : b;
                end
            end
            default: v = d;
        endcase
        return {mis, v};
    endfunction

    task automatic chk_state(input string tag);
        logic [32:0] head;
        logic        hv;
        hv   = (mq.size() != 0);
        head = hv ? mq[0] : 33'd0;
`ifdef MIPS_EXT_BYPASS_EN
        if (!hv && in_valid) begin
            hv   = 1'b1;
            head = ref_ext(mode, byte_off, data_in);
        end
`endif
        chk({tag, ".out_valid"}, out_valid, hv);
        chk({tag, ".in_ready"}, in_ready, mq.size() < DEPTH);
        chk({tag, ".count"}, count, mq.size());
        if (hv) chk({tag, ".head"}, {misalign, data_out}, head);
    endtask

    task automatic cyc(input string tag);
        logic [32:0] r;
        bit          push, pop;
        r    = ref_ext(mode, byte_off, data_in);
        pop  = out_ready && mq.size() != 0;
        push = in_valid && mq.size() < DEPTH;
`ifdef MIPS_EXT_BYPASS_EN
        if (in_valid && out_ready && mq.size() == 0) push = 0;
`endif
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(r);
        chk_state(tag);
    endtask

    task automatic one(input string tag, input logic [2:0] m,
                       input logic [1:0] off, input logic [31:0] d,
                       input logic [32:0] exp);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        mode      = m;
        byte_off  = off;
        data_in   = d;
        cyc(tag);
        in_valid = 1'b0;
        chk({tag, ".lit"}, {misalign, data_out}, exp);
        out_ready = 1'b1;
        cyc({tag, ".drain"});
        out_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.count", count, 2'd0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.data", {misalign, data_out}, 33'd0);
        @(negedge clk);
        rst = 1'b1;

        one("sext_neg", 3'd0, 2'd0, 32'h0000_8000, 33'h0_FFFF_8000);
        one("sext_pos", 3'd0, 2'd0, 32'h0000_7FFF, 33'h0_0000_7FFF);
        one("zext", 3'd1, 2'd0, 32'h0000_FFFF, 33'h0_0000_FFFF);
        one("lui", 3'd2, 2'd0, 32'h0000_1234, 33'h0_1234_0000);
        one("lb0", 3'd3, 2'd0, 32'h80FF_7F01, 33'h0_0000_0001);
        one("lb1", 3'd3, 2'd1, 32'h80FF_7F01, 33'h0_0000_007F);
        one("lb2", 3'd3, 2'd2, 32'h80FF_7F01, 33'h0_FFFF_FFFF);
        one("lb3", 3'd3, 2'd3, 32'h80FF_7F01, 33'h0_FFFF_FF80);
        one("lbu2", 3'd4, 2'd2, 32'h80FF_7F01, 33'h0_0000_00FF);
        one("lh2", 3'd5, 2'd2, 32'h80FF_7F01, 33'h0_FFFF_80FF);
        one("lhu0", 3'd6, 2'd0, 32'h80FF_7F01, 33'h0_0000_7F01);
        one("lh1_mis", 3'd5, 2'd1, 32'h80FF_7F01, 33'h1_0000_0000);
        one("pass", 3'd7, 2'd3, 32'hDEAD_BEEF, 33'h0_DEAD_BEEF);

        // Back-pressure: third request must stall while the FIFO is full
        mode = 3'd7;
        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = 32'h1111_1111;
        cyc("bp1");
        data_in = 32'h2222_2222;
        cyc("bp2");
        chk("bp.full_ready", in_ready, 1'b0);
        data_in = 32'h3333_3333;
        cyc("bp3");
        chk("bp.hold", data_out, 32'h1111_1111);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc("bp.pop1");
        chk("bp.second", data_out, 32'h2222_2222);
        cyc("bp.pop2");
        chk("bp.empty", count, 2'd0);

        // Steady push+pop at occupancy 1
        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = $urandom;
        cyc("pp.fill");
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mode = 3'($urandom_range(0, 7));
            byte_off = 2'($urandom_range(0, 3));
            data_in = $urandom;
            cyc("pp");
            chk("pp.count1", count, 2'd1);
        end
        in_valid = 1'b0;
        cyc("pp.drain");

        // Asynchronous reset while full
        out_ready = 1'b0;
        in_valid = 1'b1;
        cyc("ar.f1");
        cyc("ar.f2");
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar.out_valid", out_valid, 1'b0);
        chk("ar.count", count, 2'd0);
        chk("ar.in_ready", in_ready, 1'b1);
        chk("ar.data", {misalign, data_out}, 33'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;

`ifdef MIPS_EXT_BYPASS_EN
        in_valid = 1'b1;
        out_ready = 1'b1;
        mode = 3'd0;
        byte_off = 2'd0;
        data_in = 32'h0000_8000;
        #1;
        chk("byp.valid", out_valid, 1'b1);
        chk("byp.data", {misalign, data_out}, 33'h0_FFFF_8000);
        cyc("byp.cyc");
        chk("byp.count", count, 2'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            mode = 3'($urandom_range(0, 7));
            byte_off = 2'($urandom_range(0, 3));
            data_in = $urandom;
            cyc("rnd");
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc("end.d1");
        cyc("end.d2");
        chk("end.count", count, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
